c5_timer_gpio: RTL and testbench

//  Memory-mapped peripheral that sits directly downstream of c5_cpu on its data bus, inside soc.

---
 rtl/c5_timer_gpio.sv | 151 +++++++++++++++
 tb/tb_c5_timer_gpio.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/c5_timer_gpio.sv
// GPIO output/input registers and a prescaled 32-bit compare timer on the c5_cpu data bus.
// Reads take two cycles (pause, then registered data); writes complete in one.
module c5_timer_gpio #(
   parameter int unsigned PRESCALE = 1,
   parameter int unsigned GPIO_W   = 32,
   parameter logic [31:0] GPIO_RST = '0
) (
   input  logic              I_clk,
   input  logic              I_rst,
   input  logic              I_sel,
   input  logic [29:0]       I_address,
   input  logic [3:0]        I_byte_we,
   input  logic [31:0]       I_data_w,
   output logic [31:0]       O_data_r,
   output logic              O_mem_pause,
   input  logic [GPIO_W-1:0] I_gpio,
   output logic [GPIO_W-1:0] IO_gpio,
   output logic              O_led,
   output logic              O_intr
);

   typedef enum logic [2:0] {
      REG_GPIO_OUT = 3'd0,
      REG_GPIO_IN  = 3'd1,
      REG_CNT      = 3'd2,
      REG_CMP      = 3'd3,
      REG_CTRL     = 3'd4,
      REG_STATUS   = 3'd5,
      REG_RSVD6    = 3'd6,
      REG_RSVD7    = 3'd7
   } reg_e;

   localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   logic [GPIO_W-1:0] gpio_q, gpio_d;
   logic [GPIO_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [31:0]       cnt_q, cnt_d, cmp_q, cmp_d, data_r_q, data_r_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic              match_q, match_d, rd_pend_q, rd_pend_d;
   logic [PW-1:0]     presc_q, presc_d;

   reg_e        reg_sel;
   logic        wr_en, rd_start, tick, match_hit;
   logic [31:0] rd_val, gpio_ext, sync_ext;
   logic        unused_addr;

   assign unused_addr = ^I_address[29:3];

   always_comb begin
      reg_sel  = reg_e'(I_address[2:0]);
      wr_en    = I_sel & (|I_byte_we);
      rd_start = I_sel & ~(|I_byte_we) & ~rd_pend_q;
      tick     = ctrl_q[0] & (presc_q == PRE_MAX);
      gpio_ext = '0;
      gpio_ext[GPIO_W-1:0] = gpio_q;
      sync_ext = '0;
      sync_ext[GPIO_W-1:0] = sync2_q;
   end

   always_comb begin
      rd_val = '0;
      case (reg_sel)
         REG_GPIO_OUT: rd_val = gpio_ext;
         REG_GPIO_IN:  rd_val = sync_ext;
         REG_CNT:      rd_val = cnt_q;
         REG_CMP:      rd_val = cmp_q;
         REG_CTRL:     rd_val = {29'd0, ctrl_q};
         REG_STATUS:   rd_val = {31'd0, match_q};
         default:      rd_val = '0;
      endcase
   end

   always_comb begin
      gpio_d    = gpio_q;
      cmp_d     = cmp_q;
      ctrl_d    = ctrl_q;
      sync1_d   = I_gpio;
      sync2_d   = sync1_q;
      data_r_d  = rd_start ? rd_val : data_r_q;
      rd_pend_d = rd_start;
      presc_d   = (!ctrl_q[0] || tick) ? '0 : presc_q + 1'b1;
      if (wr_en) begin
         case (reg_sel)
            REG_GPIO_OUT: gpio_d = GPIO_W'(byte_merge(gpio_ext, I_data_w, I_byte_we));
            REG_CMP:      cmp_d  = byte_merge(cmp_q, I_data_w, I_byte_we);
            REG_CTRL:     ctrl_d = 3'(byte_merge({29'd0, ctrl_q}, I_data_w, I_byte_we));
            default:      ;
         endcase
      end
   end

   // A CPU write to CNT swallows a coincident tick, including its compare.
   always_comb begin
      cnt_d     = cnt_q;
      match_hit = 1'b0;
      if (wr_en && reg_sel == REG_CNT) begin
         cnt_d = byte_merge(cnt_q, I_data_w, I_byte_we);
      end else if (tick) begin
         match_hit = (cnt_q == cmp_q);
         cnt_d     = (match_hit && ctrl_q[2]) ? '0 : cnt_q + 32'd1;
      end
      match_d = match_q;
      if (wr_en && reg_sel == REG_STATUS && I_byte_we[0] && I_data_w[0]) match_d = 1'b0;
      if (match_hit) match_d = 1'b1;
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         gpio_q    <= GPIO_W'(GPIO_RST);
         sync1_q   <= '0;
         sync2_q   <= '0;
         cnt_q     <= '0;
         cmp_q     <= '1;
         ctrl_q    <= '0;
         match_q   <= 1'b0;
         presc_q   <= '0;
         data_r_q  <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         gpio_q    <= gpio_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cnt_q     <= cnt_d;
         cmp_q     <= cmp_d;
         ctrl_q    <= ctrl_d;
         match_q   <= match_d;
         presc_q   <= presc_d;
         data_r_q  <= data_r_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   assign O_data_r    = data_r_q;
   assign O_mem_pause = rd_start & ~I_rst;
   assign IO_gpio     = gpio_q;
   assign O_led       = gpio_q[0];
   assign O_intr      = match_q & ctrl_q[1];

endmodule

// File: tb/tb_c5_timer_gpio.sv
// Bench for c5_timer_gpio: directed bus scenarios plus randomized traffic, all
// outputs compared each cycle against a register-level reference model.
module tb_c5_timer_gpio;

   localparam int unsigned PRESCALE = 4;
   localparam int unsigned GPIO_W   = 8;
   localparam logic [31:0] GPIO_RST = 32'h0000_003C;
   localparam logic [31:0] GMASK    = 32'h0000_00FF;

   logic              clk = 1'b0;
   logic              rst;
   logic              sel;
   logic [29:0]       addr;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic [31:0]       data_r;
   logic              pause;
   logic [GPIO_W-1:0] gpio_in;
   logic [GPIO_W-1:0] gpio_out;
   logic              led;
   logic              intr;

   int n_tests = 0;
   int n_fail  = 0;

   c5_timer_gpio #(.PRESCALE(PRESCALE), .GPIO_W(GPIO_W), .GPIO_RST(GPIO_RST)) dut (
      .I_clk(clk), .I_rst(rst), .I_sel(sel), .I_address(addr), .I_byte_we(be),
      .I_data_w(wdata), .O_data_r(data_r), .O_mem_pause(pause), .I_gpio(gpio_in),
      .IO_gpio(gpio_out), .O_led(led), .O_intr(intr)
   );

   always #5 clk = ~clk;

   // reference model state
   bit          m_valid = 0;
   logic [31:0] m_gpio, m_cnt, m_cmp, m_data_r, m_s1, m_s2;
   logic [2:0]  m_ctrl;
   bit          m_match, m_rd_pend;
   int          m_enabled_cycles;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_read(input int a);
      case (a)
         0: return m_gpio;
         1: return m_s2;
         2: return m_cnt;
         3: return m_cmp;
         4: return {29'd0, m_ctrl};
         5: return {31'd0, m_match};
         default: return 32'd0;
      endcase
   endfunction

   // advance the model by one clock edge using the currently driven inputs
   task automatic model_step();
      int a;
      bit rd, wr, tick, hit;
      logic [31:0] old_cnt, old_cmp;
      logic [2:0] old_ctrl;
      if (rst) begin
         m_gpio = GPIO_RST & GMASK; m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 0;
         m_match = 0; m_enabled_cycles = 0; m_data_r = 0; m_rd_pend = 0;
         m_s1 = 0; m_s2 = 0; m_valid = 1;
         return;
      end
      a = int'(addr[2:0]);
      rd = sel && be == 0 && !m_rd_pend;
      wr = sel && be != 0;
      old_cnt = m_cnt; old_cmp = m_cmp; old_ctrl = m_ctrl;
      if (rd) m_data_r = m_read(a);
      m_rd_pend = rd;
      m_s2 = m_s1;
      m_s1 = 32'(gpio_in) & GMASK;
      tick = 0;
      if (old_ctrl[0]) begin
         m_enabled_cycles++;
         if (m_enabled_cycles == PRESCALE) begin tick = 1; m_enabled_cycles = 0; end
      end else m_enabled_cycles = 0;
      hit = 0;
      if (wr && a == 2) m_cnt = merge(old_cnt, wdata, be);
      else if (tick) begin
         hit = (old_cnt == old_cmp);
         m_cnt = (hit && old_ctrl[2]) ? 32'd0 : old_cnt + 32'd1;
      end
      if (wr && a == 5 && be[0] && wdata[0]) m_match = 0;
      if (hit) m_match = 1;
      if (wr && a == 0) m_gpio = merge(m_gpio, wdata, be) & GMASK;
      if (wr && a == 3) m_cmp = merge(old_cmp, wdata, be);
      if (wr && a == 4) m_ctrl = 3'(merge({29'd0, old_ctrl}, wdata, be));
   endtask

   task automatic cycle();
      @(negedge clk);
      if (m_valid) begin
         check("pause", 32'(pause), 32'(sel && be == 0 && !m_rd_pend && !rst));
         check("intr", 32'(intr), 32'(m_match && m_ctrl[1]));
         check("gpio_out", 32'(gpio_out), m_gpio);
         check("led", 32'(led), 32'(m_gpio[0]));
         check("data_r", data_r, m_data_r);
      end
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      sel = 0; be = 0;
      repeat (n) cycle();
   endtask

   task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] b);
      sel = 1; addr = 30'(a); be = b; wdata = d;
      cycle();
      sel = 0; be = 0;
   endtask

   task automatic bus_read(input int a, output logic [31:0] d);
      sel = 1; addr = 30'(a); be = 0; wdata = 0;
      #1 check("rd_pause", 32'(pause), 32'd1);
      cycle();
      cycle();
      d = data_r;
      sel = 0;
   endtask

   initial begin
      logic [31:0] d;
      int intr_seen;
      rst = 1; sel = 0; addr = 0; be = 0; wdata = 0; gpio_in = 0;
      @(posedge clk); #1;
      cycle(); cycle();
      rst = 0;
      check("rst_gpio", 32'(gpio_out), GPIO_RST);
      check("rst_led", 32'(led), 32'd0);
      check("rst_intr", 32'(intr), 32'd0);
      check("rst_pause", 32'(pause), 32'd0);
      check("rst_data_r", data_r, 32'd0);

      bus_write(0, 32'hA5A5_A5A5, 4'b0001);
      check("gpio_wr", 32'(gpio_out), 32'h0000_00A5);
      check("gpio_led", 32'(led), 32'd1);
      bus_read(0, d);
      check("gpio_rd", d, 32'h0000_00A5);

      gpio_in = 8'h03;
      bus_read(1, d);
      check("sync_early", d, 32'd0);
      bus_read(1, d);
      check("sync_late", d, 32'd3);

      bus_write(3, 32'd3, 4'hF);
      bus_write(2, 32'd0, 4'hF);
      bus_write(4, 32'd7, 4'h1);
      idle(15);
      check("t4_pre_match", 32'(intr), 32'd0);
      idle(1);
      check("t4_match", 32'(intr), 32'd1);
      bus_read(2, d);
      check("t4_reload", d, 32'd0);
      bus_write(5, 32'd1, 4'h1);
      check("t4_w1c", 32'(intr), 32'd0);

      bus_write(4, 32'd0, 4'h1);
      bus_write(5, 32'd1, 4'h1);
      bus_write(3, 32'd5, 4'hF);
      bus_write(2, 32'hFFFF_FFFF, 4'hF);
      bus_write(4, 32'd1, 4'h1);
      idle(6);
      bus_read(5, d);
      check("t5_wrap_nomatch", d, 32'd0);
      bus_read(2, d);
      check("t5_wrap_cnt", d, 32'd1);
      idle(30);
      bus_read(5, d);
      check("t5_match5", d, 32'd1);

      bus_write(4, 32'd0, 4'h1);
      bus_write(3, 32'd0, 4'hF);
      bus_write(2, 32'd0, 4'hF);
      bus_write(5, 32'd1, 4'h1);
      bus_write(4, 32'd7, 4'h1);
      intr_seen = 0;
      for (int i = 0; i < 8; i++) begin
         sel = 1; addr = 30'd5; be = 4'h1; wdata = 32'd1;
         cycle();
         if (intr) intr_seen++;
      end
      sel = 0; be = 0;
      check("t5_set_wins", 32'(intr_seen), 32'd2);

      bus_write(4, 32'd0, 4'h1);
      bus_write(4, 32'd1, 4'h1);
      for (int i = 0; i < 4; i++) bus_write(2, 32'h100, 4'hF);
      bus_write(4, 32'd0, 4'h1);
      bus_read(2, d);
      check("t5_cnt_wr_wins", d, 32'h100);

      sel = 1; addr = 30'd2; be = 0;
      @(negedge clk);
      check("t6_pause", 32'(pause), 32'd1);
      rst = 1;
      #1 check("t6_pause_rst", 32'(pause), 32'd0);
      model_step();
      @(posedge clk); #1;
      check("t6_data_r", data_r, 32'd0);
      check("t6_gpio", 32'(gpio_out), GPIO_RST);
      rst = 0; sel = 0;

      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         sel = ($urandom_range(0, 2) != 0);
         addr = 30'($urandom);
         be = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         case ($urandom_range(0, 3))
            0: wdata = 32'($urandom_range(0, 12));
            1: wdata = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            2: wdata = 32'($urandom_range(0, 7)) | 32'h1;
            default: wdata = $urandom;
         endcase
         gpio_in = GPIO_W'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
